id_ex_stage: RTL and testbench
==============================

// Module: id_ex_stage
// PURPOSE
//   ID/EX pipeline register fed by the register file read ports and the decoder.
//   Captures operands, immediate and control for EX.
//   Bypasses same-cycle WB writes so that EX never sees a stale operand.
//   Detects load-use hazards, stalls IF/ID and inserts a bubble.
//   Keeps a saturating stall counter for performance debug.
// PARAMETERS
//   CTRL_W   8   width of packed EX/MEM/WB control bundle (bit 0 = reg_write, bit 1 = mem_read)
//   CNT_W   16   width of stall_count
// PORTS
//   clk            in   1       pipeline clock; all state updates on posedge
//   reset          in   1       asynchronous, active-low; clears all state
//   id_rs          in   5       source register 1 index (drives ReadRegister1)
//   id_rt          in   5       source register 2 index (drives ReadRegister2)
//   id_rd          in   5       destination index of the decoded instruction
//   id_uses_rt     in   1       1 = instruction reads rt as a source
//   id_read_data1  in   32      ReadData1 from the register file
//   id_read_data2  in   32      ReadData2 from the register file
//   id_imm         in   32      sign-extended immediate
//   id_ctrl        in   CTRL_W  decoded control bundle
//   id_valid       in   1       IF/ID holds a real instruction
//   flush          in   1       branch/jump resolved taken; kill the ID instruction
//   wb_reg_write   in   1       RegWrite presented to the register file this cycle
//   wb_write_reg   in   5       WriteRegister presented to the register file
//   wb_write_data  in   32      WriteData presented to the register file
//   stall          out  1       combinational; 1 = hold PC and IF/ID this cycle
//   ex_valid       out  1       EX holds a real instruction
//   ex_rs, ex_rt, ex_rd  out  5 registered indices
//   ex_op1, ex_op2 out  32      registered operands (after bypass)
//   ex_imm         out  32      registered immediate
//   ex_ctrl        out  CTRL_W  registered control bundle
//   stall_count    out  CNT_W   number of bubble cycles inserted since reset
// BEHAVIOUR
//   Reset (reset=0, async): every registered output is 0 (ex_valid=0, ex_ctrl=0, stall_count=0).
//     Reset deasserted mid-stream: first posedge captures normally.
//   Latency: 1 cycle. ID values present before edge N appear on ex_* after edge N.
//   Bypass, per operand, evaluated combinationally before capture:
//     op1 = (wb_reg_write && wb_write_reg!=0 && wb_write_reg==id_rs) ? wb_write_data : id_read_data1
//     op2 uses the same rule against id_rt.
//     Index 0 never bypasses; register 0 reads as 0 regardless of WB.
//   Hazard:
//     stall = ex_valid & ex_ctrl[1] & (ex_rt!=0) & id_valid & ~flush
//             & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt))
//   Next-state priority on each posedge:
//     1. flush=1  -> bubble: ex_valid=0, ex_ctrl=0; flush overrides stall.
//     2. stall=1  -> bubble: ex_valid=0, ex_ctrl=0; stall_count += 1.
//     3. otherwise -> capture: ex_valid=id_valid, ex_ctrl = id_valid ? id_ctrl : 0.
//   Operand/index fields in a bubble are don't-care, but the implementation drives them to 0.
//   States: RUN (capture) and BUBBLE (one cycle).
//     A load-use stall lasts exactly 1 cycle: after the bubble ex_ctrl[1]=0, so stall drops.
//   stall_count saturates at all-ones and never wraps.
//   A simultaneous bypass and stall is legal: the stalled instruction is re-presented
//     next cycle and re-reads the register file.
// TESTING
//   1. Reset: reset=0 asserted with clk stopped -> all ex_* and stall_count read 0 immediately.
//   2. Plain capture: id_rs=3, rd1=0x11, rd2=0x22, id_ctrl=0x01, id_valid=1, no WB
//        -> next cycle ex_op1=0x11, ex_op2=0x22, ex_ctrl=0x01, ex_valid=1.
//   3. WB bypass: wb_reg_write=1, wb_write_reg=5, wb_write_data=0xDEADBEEF, id_rs=5, rd1=0
//        -> ex_op1=0xDEADBEEF; the same case with wb_write_reg=0 -> ex_op1=0.
//   4. Load-use: lw $8 in EX (ctrl[1]=1, ex_rt=8), ID add reads $8
//        -> stall=1 for 1 cycle, ex_valid=0, stall_count=1; the add issues the following cycle.
//   5. Flush and stall in the same cycle
//        -> bubble inserted, stall=0, stall_count unchanged.
//   6. Saturation: CNT_W=2, 5 load-use events -> stall_count stops at 3.

Source files
------------

// File: rtl/id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : id_ex_stage
//  Brief    : ID/EX pipeline register with WB-to-EX operand bypass, load-use
//             hazard detection (stall + bubble) and a saturating stall counter.
//  Revision : 1.0  initial release
// ============================================================================
module id_ex_stage #(
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic [4:0]        id_rs_i,
  input  logic [4:0]        id_rt_i,
  input  logic [4:0]        id_rd_i,
  input  logic              id_uses_rt_i,
  input  logic [31:0]       id_read_data1_i,
  input  logic [31:0]       id_read_data2_i,
  input  logic [31:0]       id_imm_i,
  input  logic [CTRL_W-1:0] id_ctrl_i,
  input  logic              id_valid_i,
  input  logic              flush_i,
  input  logic              wb_reg_write_i,
  input  logic [4:0]        wb_write_reg_i,
  input  logic [31:0]       wb_write_data_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [4:0]        ex_rs_o,
  output logic [4:0]        ex_rt_o,
  output logic [4:0]        ex_rd_o,
  output logic [31:0]       ex_op1_o,
  output logic [31:0]       ex_op2_o,
  output logic [31:0]       ex_imm_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic [CNT_W-1:0]  stall_count_o
);

  localparam logic [0:0] ST_RUN    = 1'b0;
  localparam logic [0:0] ST_BUBBLE = 1'b1;

  logic [0:0]        state_q, state_d;
  logic              valid_q, valid_d;
  logic [4:0]        rs_q, rs_d, rt_q, rt_d, rd_q, rd_d;
  logic [31:0]       op1_q, op1_d, op2_q, op2_d, imm_q, imm_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              byp1, byp2, stall;

  // Forward a same-cycle WB write; register 0 is hard-wired and never forwarded
  always_comb begin
    byp1 = wb_reg_write_i && (wb_write_reg_i != 5'd0) && (wb_write_reg_i == id_rs_i);
    byp2 = wb_reg_write_i && (wb_write_reg_i != 5'd0) && (wb_write_reg_i == id_rt_i);
  end

  // Load in EX whose destination feeds the ID instruction; a flush cancels the hazard
  always_comb begin
    stall = ex_valid_o && ctrl_q[1] && (rt_q != 5'd0) && id_valid_i && !flush_i
            && ((rt_q == id_rs_i) || (id_uses_rt_i && (rt_q == id_rt_i)));
  end

  assign stall_o = stall;

  // State register plus the EX payload it qualifies
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_RUN;
      valid_q <= 1'b0;
      rs_q    <= 5'd0;
      rt_q    <= 5'd0;
      rd_q    <= 5'd0;
      op1_q   <= 32'd0;
      op2_q   <= 32'd0;
      imm_q   <= 32'd0;
      ctrl_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rs_q    <= rs_d;
      rt_q    <= rt_d;
      rd_q    <= rd_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      imm_q   <= imm_d;
      ctrl_q  <= ctrl_d;
      cnt_q   <= cnt_d;
    end
  end

  // Flush or load-use hazard makes the next EX cycle a bubble
  always_comb begin
    state_d = ST_RUN;
    if (flush_i || stall) begin
      state_d = ST_BUBBLE;
    end
  end

  // Capture ID contents in RUN, zero everything in BUBBLE; count hazard bubbles only
  always_comb begin
    valid_d = 1'b0;
    rs_d    = 5'd0;
    rt_d    = 5'd0;
    rd_d    = 5'd0;
    op1_d   = 32'd0;
    op2_d   = 32'd0;
    imm_d   = 32'd0;
    ctrl_d  = '0;
    cnt_d   = cnt_q;
    if (state_d == ST_RUN) begin
      valid_d = id_valid_i;
      rs_d    = id_rs_i;
      rt_d    = id_rt_i;
      rd_d    = id_rd_i;
      op1_d   = byp1 ? wb_write_data_i : id_read_data1_i;
      op2_d   = byp2 ? wb_write_data_i : id_read_data2_i;
      imm_d   = id_imm_i;
      ctrl_d  = id_valid_i ? id_ctrl_i : '0;
    end
    if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign ex_valid_o    = valid_q && (state_q == ST_RUN);
  assign ex_rs_o       = rs_q;
  assign ex_rt_o       = rt_q;
  assign ex_rd_o       = rd_q;
  assign ex_op1_o      = op1_q;
  assign ex_op2_o      = op2_q;
  assign ex_imm_o      = imm_q;
  assign ex_ctrl_o     = ctrl_q;
  assign stall_count_o = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_id_ex_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_id_ex_stage
//  Brief    : Directed scoreboard bench for id_ex_stage (wide and 2-bit counter).
//  Revision : 1.0  initial release
// ============================================================================
module tb_id_ex_stage;

  typedef struct {
    logic        valid;
    logic [7:0]  ctrl;
    logic [4:0]  rs, rt, rd;
    logic [31:0] op1, op2, imm;
    logic [15:0] cnt;
    logic [1:0]  cnt2;
  } exp_t;

  logic clk = 1'b0, clk_en = 1'b0, rst_n = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_rd = '0, wb_reg = '0;
  logic id_uses_rt = 1'b0, id_valid = 1'b0, flush = 1'b0, wb_we = 1'b0;
  logic [31:0] rd1 = '0, rd2 = '0, imm = '0, wb_data = '0;
  logic [7:0] id_ctrl = '0;

  logic stall, ex_valid, stall2, ex_valid2;
  logic [4:0] ex_rs, ex_rt, ex_rd, ex_rs2, ex_rt2, ex_rd2;
  logic [31:0] ex_op1, ex_op2, ex_imm, ex_op1b, ex_op2b, ex_immb;
  logic [7:0] ex_ctrl, ex_ctrl2;
  logic [15:0] cnt;
  logic [1:0] cnt2;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  exp_t m;   // model of the current EX register contents

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  id_ex_stage #(.CTRL_W(8), .CNT_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .id_uses_rt_i(id_uses_rt), .id_read_data1_i(rd1), .id_read_data2_i(rd2),
    .id_imm_i(imm), .id_ctrl_i(id_ctrl), .id_valid_i(id_valid), .flush_i(flush),
    .wb_reg_write_i(wb_we), .wb_write_reg_i(wb_reg), .wb_write_data_i(wb_data),
    .stall_o(stall), .ex_valid_o(ex_valid), .ex_rs_o(ex_rs), .ex_rt_o(ex_rt),
    .ex_rd_o(ex_rd), .ex_op1_o(ex_op1), .ex_op2_o(ex_op2), .ex_imm_o(ex_imm),
    .ex_ctrl_o(ex_ctrl), .stall_count_o(cnt)
  );

  id_ex_stage #(.CTRL_W(8), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_ni(rst_n), .id_rs_i(id_rs), .id_rt_i(id_rt), .id_rd_i(id_rd),
    .id_uses_rt_i(id_uses_rt), .id_read_data1_i(rd1), .id_read_data2_i(rd2),
    .id_imm_i(imm), .id_ctrl_i(id_ctrl), .id_valid_i(id_valid), .flush_i(flush),
    .wb_reg_write_i(wb_we), .wb_write_reg_i(wb_reg), .wb_write_data_i(wb_data),
    .stall_o(stall2), .ex_valid_o(ex_valid2), .ex_rs_o(ex_rs2), .ex_rt_o(ex_rt2),
    .ex_rd_o(ex_rd2), .ex_op1_o(ex_op1b), .ex_op2_o(ex_op2b), .ex_imm_o(ex_immb),
    .ex_ctrl_o(ex_ctrl2), .stall_count_o(cnt2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_id(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic uses, input logic [31:0] d1, input logic [31:0] d2,
                        input logic [31:0] im, input logic [7:0] ct, input logic v);
    id_rs = rs; id_rt = rt; id_rd = rd; id_uses_rt = uses;
    rd1 = d1; rd2 = d2; imm = im; id_ctrl = ct; id_valid = v;
  endtask

  task automatic set_wb(input logic we, input logic [4:0] r, input logic [31:0] d);
    wb_we = we; wb_reg = r; wb_data = d;
  endtask

  task automatic model_reset();
    m = '{valid: 1'b0, ctrl: 8'h0, rs: 5'h0, rt: 5'h0, rd: 5'h0,
          op1: 32'h0, op2: 32'h0, imm: 32'h0, cnt: 16'h0, cnt2: 2'h0};
  endtask

  // Check stall with inputs settled, predict the edge, then compare after it
  task automatic cycle(input string tag);
    logic exp_stall;
    exp_t e;
    #1;
    exp_stall = m.valid && m.ctrl[1] && (m.rt != 5'd0) && id_valid && !flush
                && ((m.rt == id_rs) || (id_uses_rt && (m.rt == id_rt)));
    chk({tag, ".stall"}, {31'd0, stall}, {31'd0, exp_stall});
    chk({tag, ".stall_sat"}, {31'd0, stall2}, {31'd0, exp_stall});
    e = '{valid: 1'b0, ctrl: 8'h0, rs: 5'h0, rt: 5'h0, rd: 5'h0,
          op1: 32'h0, op2: 32'h0, imm: 32'h0, cnt: m.cnt, cnt2: m.cnt2};
    if (!flush && !exp_stall) begin
      e.valid = id_valid;
      e.ctrl  = id_valid ? id_ctrl : 8'h0;
      e.rs = id_rs; e.rt = id_rt; e.rd = id_rd; e.imm = imm;
      e.op1 = (wb_we && wb_reg != 5'd0 && wb_reg == id_rs) ? wb_data : rd1;
      e.op2 = (wb_we && wb_reg != 5'd0 && wb_reg == id_rt) ? wb_data : rd2;
    end
    if (exp_stall) begin
      if (e.cnt != 16'hFFFF) e.cnt = e.cnt + 16'd1;
      if (e.cnt2 != 2'b11) e.cnt2 = e.cnt2 + 2'd1;
    end
    q.push_back(e);
    m = e;
    @(posedge clk);
    #1;
    e = q.pop_front();
    chk({tag, ".valid"}, {31'd0, ex_valid}, {31'd0, e.valid});
    chk({tag, ".ctrl"}, {24'd0, ex_ctrl}, {24'd0, e.ctrl});
    chk({tag, ".rs"}, {27'd0, ex_rs}, {27'd0, e.rs});
    chk({tag, ".rt"}, {27'd0, ex_rt}, {27'd0, e.rt});
    chk({tag, ".rd"}, {27'd0, ex_rd}, {27'd0, e.rd});
    chk({tag, ".op1"}, ex_op1, e.op1);
    chk({tag, ".op2"}, ex_op2, e.op2);
    chk({tag, ".imm"}, ex_imm, e.imm);
    chk({tag, ".cnt"}, {16'd0, cnt}, {16'd0, e.cnt});
    chk({tag, ".cnt_sat"}, {30'd0, cnt2}, {30'd0, e.cnt2});
  endtask

  task automatic check_zero(input string tag);
    chk({tag, ".valid"}, {31'd0, ex_valid}, 32'd0);
    chk({tag, ".ctrl"}, {24'd0, ex_ctrl}, 32'd0);
    chk({tag, ".ops"}, ex_op1 | ex_op2 | ex_imm, 32'd0);
    chk({tag, ".idx"}, {17'd0, ex_rs, ex_rt, ex_rd}, 32'd0);
    chk({tag, ".cnt"}, {16'd0, cnt}, 32'd0);
    chk({tag, ".cnt_sat"}, {30'd0, cnt2}, 32'd0);
  endtask

  initial begin
    model_reset();
    // Reset with the clock stopped
    #1;
    check_zero("reset");
    rst_n = 1'b1;
    clk_en = 1'b1;

    // Plain capture
    set_id(5'd3, 5'd4, 5'd6, 1'b1, 32'h11, 32'h22, 32'h7, 8'h01, 1'b1);
    cycle("plain");
    chk("plain.op1_const", ex_op1, 32'h11);
    chk("plain.op2_const", ex_op2, 32'h22);

    // WB bypass on op1, then through register 0, then on op2
    set_wb(1'b1, 5'd5, 32'hDEADBEEF);
    set_id(5'd5, 5'd7, 5'd2, 1'b1, 32'h0, 32'h33, 32'hFFFF_FFF0, 8'h01, 1'b1);
    cycle("byp1");
    chk("byp1.op1_const", ex_op1, 32'hDEADBEEF);
    set_wb(1'b1, 5'd0, 32'hDEADBEEF);
    set_id(5'd0, 5'd7, 5'd2, 1'b1, 32'h0, 32'h33, 32'h1, 8'h01, 1'b1);
    cycle("byp_r0");
    chk("byp_r0.op1_const", ex_op1, 32'h0);
    set_wb(1'b1, 5'd9, 32'hCAFE_0009);
    set_id(5'd1, 5'd9, 5'd4, 1'b1, 32'h5, 32'h0, 32'h2, 8'h01, 1'b1);
    cycle("byp2");
    set_wb(1'b0, 5'd0, 32'h0);

    // Load-use: lw $8 then add reading $8 -> one bubble, then the add issues
    set_id(5'd2, 5'd8, 5'd0, 1'b0, 32'h100, 32'h0, 32'h4, 8'h03, 1'b1);
    cycle("lw8");
    set_id(5'd8, 5'd3, 5'd9, 1'b1, 32'hAA, 32'hBB, 32'h0, 8'h01, 1'b1);
    cycle("lu_stall");
    chk("lu_stall.cnt_const", {16'd0, cnt}, 32'd1);
    cycle("lu_issue");

    // Load whose rt is only matched through an unused rt: no stall
    set_id(5'd2, 5'd10, 5'd0, 1'b0, 32'h200, 32'h0, 32'h8, 8'h03, 1'b1);
    cycle("lw10");
    set_id(5'd1, 5'd10, 5'd11, 1'b0, 32'h1, 32'h2, 32'h0, 8'h01, 1'b1);
    cycle("no_use_rt");

    // Flush and hazard together: bubble, no stall, counter unchanged
    set_id(5'd2, 5'd10, 5'd0, 1'b0, 32'h200, 32'h0, 32'h8, 8'h03, 1'b1);
    cycle("lw10b");
    set_id(5'd10, 5'd3, 5'd12, 1'b1, 32'h1, 32'h2, 32'h0, 8'h01, 1'b1);
    flush = 1'b1;
    cycle("flush_stall");
    chk("flush_stall.cnt_const", {16'd0, cnt}, 32'd1);
    flush = 1'b0;

    // Idle slot: id_valid=0 gates control
    set_id(5'd1, 5'd2, 5'd3, 1'b0, 32'h9, 32'h9, 32'h9, 8'hFF, 1'b0);
    cycle("idle");

    // Four more load-use events: wide counter reaches 5, 2-bit one holds at 3
    for (int i = 0; i < 4; i++) begin
      set_id(5'd2, 5'd12, 5'd0, 1'b0, 32'h300 + i, 32'h0, 32'h0, 8'h03, 1'b1);
      cycle("sat_lw");
      set_id(5'd4, 5'd12, 5'd13, 1'b1, 32'h1, 32'h2, 32'h0, 8'h01, 1'b1);
      cycle("sat_stall");
      cycle("sat_issue");
    end
    chk("sat.cnt_const", {16'd0, cnt}, 32'd5);
    chk("sat.cnt2_const", {30'd0, cnt2}, 32'd3);

    // Mid-stream asynchronous reset with the clock held low, then resume
    @(negedge clk);
    clk_en = 1'b0;
    #1;
    rst_n = 1'b0;
    #1;
    check_zero("reset_mid");
    model_reset();
    rst_n = 1'b1;
    clk_en = 1'b1;
    set_id(5'd7, 5'd8, 5'd9, 1'b1, 32'h77, 32'h88, 32'h99, 8'h05, 1'b1);
    cycle("post_reset");

    chk("scoreboard_empty", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL timeout observed=running expected=finished");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
